// File: rtl/topk_pkg.sv
// Shared definitions for the top-5 sort pipeline: entry layout, empty-slot marker,
// drain state encoding and the leading-valid-entry counter.
package topk_pkg;

  localparam int Data_Width  = 8;
  localparam int Index_Width = 16;
  localparam int K           = 5;
  localparam int W           = Index_Width + Data_Width;

  typedef logic [W-1:0] entry_t;
  typedef entry_t entry_arr_t [K];

  // Empty slot: index 0 with the most negative score.
  localparam entry_t MIN = entry_t'(2 ** (Data_Width - 1));

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  function automatic logic [Index_Width-1:0] entry_index(input entry_t e);
    return e[W-1:Data_Width];
  endfunction

  function automatic logic [Data_Width-1:0] entry_score(input entry_t e);
    return e[Data_Width-1:0];
  endfunction

  // Position of the first MIN slot (K when none); empty slots are always trailing.
  function automatic logic [2:0] count_valid(input entry_arr_t e);
    logic [2:0] c;
    c = 3'(K);
    for (int i = K - 1; i >= 0; i--) begin
      if (e[i] == MIN) c = 3'(i);
    end
    return c;
  endfunction

endpackage

// File: rtl/topk_drain_if.sv
// Result stream of the drain. Handshake: a beat transfers on a cycle where res_valid
// and res_ready are both high; once raised, res_valid and payload hold until that cycle.
interface topk_drain_if;
  import topk_pkg::*;

  logic                   res_valid;
  logic                   res_ready;
  logic [Index_Width-1:0] res_index;
  logic [Data_Width-1:0]  res_data;
  logic [2:0]             res_rank;
  logic                   res_last;

  modport master (
    output res_valid, res_index, res_data, res_rank, res_last,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_index, res_data, res_rank, res_last,
    output res_ready
  );

endinterface

// File: rtl/topk_drain.sv
// Captures the final ranked entries of a sort pass, streams the non-empty ones best
// first, then pulses sorter_clr/done so the pipeline can start the next pass.
module topk_drain
  import topk_pkg::*;
(
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          sorter_valid,
  input  logic          last_sort_i,
  input  entry_t        sorter_out0,
  input  entry_t        sorter_out1,
  input  entry_t        sorter_out2,
  input  entry_t        sorter_out3,
  input  entry_t        sorter_out4,
  topk_drain_if.master  res,
  output logic          sorter_clr,
  output logic          done,
  output logic          empty,
  output logic          overrun,
  output state_e        dbg_state
);

  state_e     state_q, state_d;
  entry_arr_t cap_q, cap_d;
  entry_arr_t in_ent;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       clr_q, clr_d;
  logic       empty_q, empty_d;
  logic       overrun_q, overrun_d;
  logic       capture_ev;
  logic       handshake;
  logic       at_last;

  assign in_ent     = '{sorter_out0, sorter_out1, sorter_out2, sorter_out3, sorter_out4};
  assign capture_ev = sorter_valid && last_sort_i;
  assign at_last    = (ptr_q == cnt_q - 3'd1);

  // res_valid comes straight from state so it never depends on res_ready.
  assign res.res_valid = (state_q == ST_SEND);
  assign handshake     = res.res_valid && res.res_ready;

  // Payload is gated so idle outputs read as zero rather than the MIN-filled store.
  assign res.res_index = res.res_valid ? entry_index(cap_q[ptr_q]) : '0;
  assign res.res_data  = res.res_valid ? entry_score(cap_q[ptr_q]) : '0;
  assign res.res_rank  = res.res_valid ? ptr_q : 3'd0;
  assign res.res_last  = res.res_valid && at_last;

  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q | (capture_ev && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (capture_ev) begin
          cap_d   = in_ent;
          cnt_d   = count_valid(in_ent);
          ptr_d   = 3'd0;
          state_d = (cnt_d != 3'd0) ? ST_SEND : ST_CLEAR;
        end
      end
      ST_SEND: begin
        if (handshake) begin
          if (at_last) begin
            ptr_d   = 3'd0;
            state_d = ST_CLEAR;
          end else begin
            ptr_d = ptr_q + 3'd1;
          end
        end
      end
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    clr_d   = (state_d == ST_CLEAR);
    empty_d = (state_d == ST_CLEAR) && (cnt_d == 3'd0);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 3'd0;
      cnt_q     <= 3'd0;
      clr_q     <= 1'b0;
      empty_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < K; i++) cap_q[i] <= MIN;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      clr_q     <= clr_d;
      empty_q   <= empty_d;
      overrun_q <= overrun_d;
      cap_q     <= cap_d;
    end
  end

  assign sorter_clr = clr_q;
  assign done       = clr_q;
  assign empty      = empty_q;
  assign overrun    = overrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_topk_drain.sv
// Directed bench for topk_drain: expected beats are queued at capture time and a
// negedge monitor pops and compares every accepted beat and checks stall stability.
module tb_topk_drain;
  import topk_pkg::*;

  localparam int PW = 1 + 3 + Index_Width + Data_Width;

  logic   sys_clk;
  logic   sys_rst;
  logic   sorter_valid;
  logic   last_sort_i;
  entry_t sorter_out0, sorter_out1, sorter_out2, sorter_out3, sorter_out4;
  logic   sorter_clr, done, empty, overrun;
  state_e dbg_state;

  topk_drain_if res_if ();

  topk_drain dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .sorter_valid (sorter_valid),
    .last_sort_i  (last_sort_i),
    .sorter_out0  (sorter_out0),
    .sorter_out1  (sorter_out1),
    .sorter_out2  (sorter_out2),
    .sorter_out3  (sorter_out3),
    .sorter_out4  (sorter_out4),
    .res          (res_if),
    .sorter_clr   (sorter_clr),
    .done         (done),
    .empty        (empty),
    .overrun      (overrun),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  int            total_checks = 0;
  int            passed_checks = 0;
  int            clr_count = 0;
  logic          stall_q = 1'b0;
  logic [PW-1:0] stall_pl = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [PW-1:0] beat(input logic last, input logic [2:0] rank,
                                         input logic [Index_Width-1:0] idx,
                                         input logic [Data_Width-1:0] data);
    return {last, rank, idx, data};
  endfunction

  always @(negedge sys_clk) begin
    logic [PW-1:0] act;
    act = {res_if.res_last, res_if.res_rank, res_if.res_index, res_if.res_data};
    if (sys_rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid_held", res_if.res_valid, 1);
        check("stall_payload", act, stall_pl);
      end
      if (res_if.res_valid && res_if.res_ready) begin
        if (exp_q.size() == 0) begin
          total_checks++;
          $display("FAIL unexpected_beat: got %0h expected no beat", act);
        end else begin
          check("beat", act, exp_q.pop_front());
        end
      end
      stall_q  = res_if.res_valid && !res_if.res_ready;
      stall_pl = act;
      if (sorter_clr) clr_count++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic capture(input entry_t e0, e1, e2, e3, e4, input logic last);
    @(posedge sys_clk); #1;
    sorter_valid = 1'b1;
    last_sort_i  = last;
    sorter_out0 = e0; sorter_out1 = e1; sorter_out2 = e2; sorter_out3 = e3; sorter_out4 = e4;
    @(posedge sys_clk); #1;
    sorter_valid = 1'b0;
    last_sort_i  = 1'b0;
  endtask

  // Waits for the clear pulse counting cycles after capture; exp_off < 0 skips timing.
  task automatic wait_clr(input int start, input int exp_off, input logic exp_empty);
    int got;
    got = -1;
    for (int c = start; c < start + 60; c++) begin
      @(negedge sys_clk);
      if (sorter_clr) begin
        got = c;
        break;
      end
    end
    if (exp_off >= 0) check("clr_cycle", got, exp_off);
    else check("clr_seen", (got > 0), 1);
    if (got > 0) begin
      check("done_with_clr", done, 1);
      check("empty_with_clr", empty, exp_empty);
      @(negedge sys_clk);
      check("clr_one_cycle", sorter_clr, 0);
      check("done_one_cycle", done, 0);
    end
  endtask

  task automatic push_full(input int n);
    logic [PW-1:0] full_beats [5];
    full_beats = '{beat(0, 0, 16'h0012, 8'h7F), beat(0, 1, 16'h0034, 8'h05),
                   beat(0, 2, 16'h0001, 8'hFE), beat(0, 3, 16'h0007, 8'hF0),
                   beat(1, 4, 16'h0009, 8'h81)};
    for (int i = 0; i < n; i++) exp_q.push_back(full_beats[i]);
  endtask

  task automatic capture_full();
    capture(24'h00127F, 24'h003405, 24'h0001FE, 24'h0007F0, 24'h000981, 1'b1);
  endtask

  task automatic capture_partial();
    exp_q.push_back(beat(0, 0, 16'h000A, 8'h10));
    exp_q.push_back(beat(1, 1, 16'h000B, 8'h0F));
    capture(24'h000A10, 24'h000B0F, MIN, MIN, MIN, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, res_if.res_valid, 0);
    check({tag, "_index"}, res_if.res_index, 0);
    check({tag, "_data"},  res_if.res_data, 0);
    check({tag, "_rank"},  res_if.res_rank, 0);
    check({tag, "_last"},  res_if.res_last, 0);
    check({tag, "_clr"},   sorter_clr, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_empty"}, empty, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int clr_before;
    sys_rst = 1'b1;
    sorter_valid = 1'b0;
    last_sort_i = 1'b0;
    sorter_out0 = '0; sorter_out1 = '0; sorter_out2 = '0; sorter_out3 = '0; sorter_out4 = '0;
    res_if.res_ready = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    check_all_zero("reset");

    // Full pass, ready held high
    @(posedge sys_clk); #1 res_if.res_ready = 1'b1;
    push_full(5);
    capture_full();
    @(negedge sys_clk);
    check("full_valid_T1", res_if.res_valid, 1);
    check("full_rank_T1", res_if.res_rank, 0);
    wait_clr(2, 6, 1'b0);

    // Partial pass
    capture_partial();
    wait_clr(1, 3, 1'b0);

    // All-empty pass
    capture(MIN, MIN, MIN, MIN, MIN, 1'b1);
    wait_clr(1, 1, 1'b1);

    // Backpressure: ready 0,0,1,0,1,...
    @(posedge sys_clk); #1 res_if.res_ready = 1'b0;
    clr_before = clr_count;
    push_full(5);
    capture_full();
    for (int i = 0; i < 14; i++) begin
      res_if.res_ready = (i >= 2) && (i % 2 == 0);
      @(posedge sys_clk); #1;
    end
    res_if.res_ready = 1'b1;
    check("bp_clr_count", clr_count - clr_before, 1);
    check("bp_queue_drained", exp_q.size(), 0);

    // Intermediate result ignored, then overrun during SEND
    res_if.res_ready = 1'b0;
    push_full(5);
    capture_full();
    @(posedge sys_clk); #1;
    sorter_valid = 1'b1; last_sort_i = 1'b0;
    sorter_out0 = 24'hFFFF01; sorter_out1 = 24'hEEEE02; sorter_out2 = MIN;
    @(posedge sys_clk); #1 sorter_valid = 1'b0;
    @(negedge sys_clk);
    check("intermediate_no_overrun", overrun, 0);
    check("intermediate_still_send", dbg_state, ST_SEND);
    capture(24'hABCD11, 24'hABCD10, 24'hABCD0F, 24'hABCD0E, 24'hABCD0D, 1'b1);
    @(negedge sys_clk);
    check("overrun_set", overrun, 1);
    @(posedge sys_clk); #1 res_if.res_ready = 1'b1;
    wait_clr(1, -1, 1'b0);
    check("overrun_sticky", overrun, 1);

    // Reset after two beats
    push_full(2);
    capture_full();
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    res_if.res_ready = 1'b0;
    @(posedge sys_clk); #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    check_all_zero("midrst");
    clr_before = clr_count;
    repeat (3) @(negedge sys_clk);
    check("midrst_no_clr", clr_count - clr_before, 0);
    check("midrst_queue_drained", exp_q.size(), 0);
    @(posedge sys_clk); #1 res_if.res_ready = 1'b1;
    capture_partial();
    @(negedge sys_clk);
    check("restart_valid", res_if.res_valid, 1);
    check("restart_rank", res_if.res_rank, 0);
    wait_clr(2, 3, 1'b0);

    repeat (3) @(posedge sys_clk);
    check("final_queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", passed_checks, total_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
